// File: rtl/regfile_pkg.sv
// Shared register-file constants: default geometry and the hardwired-zero index.
// Used by the register file, decode and the hazard unit.
package regfile_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int AW_DEFAULT    = $clog2(NREGS_DEFAULT);
    localparam int ZERO_REG      = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: claims set, writebacks clear, claim wins on collision.
// Keeps a running popcount and answers per-read-port busy lookups.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int  NREGS = NREGS_DEFAULT,
    parameter int  NREAD = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREAD*AW-1:0] rs_addr,
    output logic [NREAD-1:0]    rs_busy,
    input  logic                we,
    input  logic [AW-1:0]       rd_addr,
    input  logic                claim,
    input  logic [AW-1:0]       claim_addr,
    output logic [AW:0]         busy_count
);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;
    logic             set_en;
    logic             clr_en;
    logic             inc;
    logic             dec;

    assign set_en = claim && (claim_addr != AW'(ZERO_REG));
    assign clr_en = we && (rd_addr != AW'(ZERO_REG));

    // A release of the register being re-claimed in the same cycle is not a net release.
    assign inc = set_en && !busy[claim_addr];
    assign dec = clr_en && busy[rd_addr] && !(set_en && (claim_addr == rd_addr));

    always_comb begin
        busy_next = busy;
        if (clr_en) begin
            busy_next[rd_addr] = 1'b0;
        end
        if (set_en) begin
            busy_next[claim_addr] = 1'b1;
        end
        busy_next[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= busy_count + (AW+1)'(inc) - (AW+1)'(dec);
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_port
        logic [AW-1:0] addr;
        assign addr       = rs_addr[i*AW +: AW];
        assign rs_busy[i] = (addr != AW'(ZERO_REG)) && busy[addr] && !(we && (rd_addr == addr));
    end

endmodule

// File: rtl/regfile_bypass.sv
// Integer register file: NREAD combinational read ports with write-to-read bypass,
// one write port, x0 hardwired to zero, and an in-flight producer scoreboard.
module regfile_bypass
    import regfile_pkg::*;
#(
    parameter int  XLEN  = XLEN_DEFAULT,
    parameter int  NREGS = NREGS_DEFAULT,
    parameter int  NREAD = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREAD*AW-1:0]   rs_addr,
    output logic [NREAD*XLEN-1:0] rs_data,
    output logic [NREAD-1:0]      rs_busy,
    input  logic                  we,
    input  logic [AW-1:0]         rd_addr,
    input  logic [XLEN-1:0]       rd_data,
    input  logic                  claim,
    input  logic [AW-1:0]         claim_addr,
    output logic [AW:0]           busy_count
);

    logic [XLEN-1:0] regs [NREGS];
    logic            write_en;

    assign write_en = we && (rd_addr != AW'(ZERO_REG));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else if (write_en) begin
            regs[rd_addr] <= rd_data;
        end
    end

    // Bypass lets an instruction reading a register in the writeback cycle see the new value.
    for (genvar i = 0; i < NREAD; i++) begin : g_read
        logic [AW-1:0] addr;
        assign addr = rs_addr[i*AW +: AW];

        always_comb begin
            rs_data[i*XLEN +: XLEN] = '0;
            if (addr == AW'(ZERO_REG)) begin
                rs_data[i*XLEN +: XLEN] = '0;
            end else if (write_en && (rd_addr == addr)) begin
                rs_data[i*XLEN +: XLEN] = rd_data;
            end else begin
                rs_data[i*XLEN +: XLEN] = regs[addr];
            end
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NREAD (NREAD)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs_addr    (rs_addr),
        .rs_busy    (rs_busy),
        .we         (we),
        .rd_addr    (rd_addr),
        .claim      (claim),
        .claim_addr (claim_addr),
        .busy_count (busy_count)
    );

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed scoreboard bench for regfile_bypass (NREGS=16, NREAD=3): stimulus pushes
// expected outputs into a queue, a negedge monitor pops and compares them.
module tb_regfile_bypass;

    localparam int XLEN  = 32;
    localparam int NREGS = 16;
    localparam int NREAD = 3;
    localparam int AW    = 4;

    logic                  clk;
    logic                  rst_n;
    logic [NREAD*AW-1:0]   rs_addr;
    logic [NREAD*XLEN-1:0] rs_data;
    logic [NREAD-1:0]      rs_busy;
    logic                  we;
    logic [AW-1:0]         rd_addr;
    logic [XLEN-1:0]       rd_data;
    logic                  claim;
    logic [AW-1:0]         claim_addr;
    logic [AW:0]           busy_count;

    typedef enum logic [1:0] {K_DATA, K_BUSY, K_COUNT} kind_t;

    typedef struct {
        string       name;
        kind_t       kind;
        int          port;
        logic [31:0] value;
    } exp_t;

    exp_t exp_q[$];
    int   total_checks;
    int   passed_checks;

    regfile_bypass #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NREAD (NREAD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs_addr    (rs_addr),
        .rs_data    (rs_data),
        .rs_busy    (rs_busy),
        .we         (we),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .claim      (claim),
        .claim_addr (claim_addr),
        .busy_count (busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic w, input logic [AW-1:0] rd, input logic [31:0] d,
                                 input logic c, input logic [AW-1:0] ca,
                                 input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                 input logic [AW-1:0] a2);
        @(posedge clk);
        #1;
        we         = w;
        rd_addr    = rd;
        rd_data    = d;
        claim      = c;
        claim_addr = ca;
        rs_addr    = {a2, a1, a0};
    endtask

    task automatic push_exp(input string name, input kind_t kind, input int port,
                            input logic [31:0] value);
        exp_t e;
        e.name  = name;
        e.kind  = kind;
        e.port  = port;
        e.value = value;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [31:0] actual;
        case (e.kind)
            K_DATA:  actual = rs_data[e.port*XLEN +: XLEN];
            K_BUSY:  actual = {31'b0, rs_busy[e.port]};
            default: actual = {27'b0, busy_count};
        endcase
        total_checks++;
        if (actual === e.value) begin
            passed_checks++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", e.name, actual, e.value);
        end
    endtask

    // Monitor: the register file answers combinationally, so every queued expectation
    // refers to the outputs of the cycle in which it was pushed.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        rst_n      = 1'b0;
        we         = 1'b0;
        rd_addr    = '0;
        rd_data    = '0;
        claim      = 1'b0;
        claim_addr = '0;
        rs_addr    = '0;

        applyStimulus(0, 0, 0, 0, 0, 5, 0, 0);
        push_exp("reset_data", K_DATA, 0, 32'h0);
        push_exp("reset_busy", K_BUSY, 0, 32'h0);
        push_exp("reset_count", K_COUNT, 0, 32'd0);

        applyStimulus(1, 5, 32'hDEADBEEF, 1, 5, 5, 0, 0);
        rst_n = 1'b1;
        push_exp("x5_bypass", K_DATA, 0, 32'hDEADBEEF);
        push_exp("x5_busy_write_claim", K_BUSY, 0, 32'h0);

        applyStimulus(0, 0, 0, 0, 0, 5, 0, 0);
        push_exp("x5_stored", K_DATA, 0, 32'hDEADBEEF);
        push_exp("x5_busy_claim_wins", K_BUSY, 0, 32'h1);
        push_exp("count_x5", K_COUNT, 0, 32'd1);

        applyStimulus(0, 0, 0, 0, 0, 5, 0, 0);
        #2 rst_n = 1'b0;
        push_exp("async_reset_data", K_DATA, 0, 32'h0);
        push_exp("async_reset_busy", K_BUSY, 0, 32'h0);
        push_exp("async_reset_count", K_COUNT, 0, 32'd0);

        applyStimulus(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int p = 0; p < NREAD; p++) begin
            push_exp($sformatf("x0_data_p%0d", p), K_DATA, p, 32'h0);
            push_exp($sformatf("x0_busy_p%0d", p), K_BUSY, p, 32'h0);
        end

        applyStimulus(0, 0, 0, 0, 0, 0, 5, 0);
        push_exp("x0_after_write", K_DATA, 0, 32'h0);
        push_exp("x5_cleared", K_DATA, 1, 32'h0);
        push_exp("x0_claim_count", K_COUNT, 0, 32'd0);

        applyStimulus(1, 3, 32'h11, 0, 0, 3, 0, 0);
        applyStimulus(1, 3, 32'h22, 0, 0, 3, 3, 4);
        push_exp("bypass_p0", K_DATA, 0, 32'h22);
        push_exp("bypass_p1", K_DATA, 1, 32'h22);
        push_exp("nonbypass_p2", K_DATA, 2, 32'h0);

        applyStimulus(0, 0, 0, 1, 7, 3, 7, 0);
        push_exp("x3_stored", K_DATA, 0, 32'h22);
        push_exp("x7_claim_same_cycle", K_BUSY, 1, 32'h0);
        push_exp("count_before_claim", K_COUNT, 0, 32'd0);

        applyStimulus(0, 0, 0, 0, 0, 7, 0, 0);
        push_exp("x7_busy", K_BUSY, 0, 32'h1);
        push_exp("count_x7", K_COUNT, 0, 32'd1);

        applyStimulus(1, 7, 32'h55, 0, 0, 7, 0, 0);
        push_exp("x7_busy_during_write", K_BUSY, 0, 32'h0);
        push_exp("x7_bypass", K_DATA, 0, 32'h55);
        push_exp("count_during_release", K_COUNT, 0, 32'd1);

        applyStimulus(0, 0, 0, 1, 9, 7, 0, 0);
        push_exp("x7_released", K_BUSY, 0, 32'h0);
        push_exp("x7_stored", K_DATA, 0, 32'h55);
        push_exp("count_released", K_COUNT, 0, 32'd0);

        applyStimulus(1, 9, 32'hAA, 1, 9, 9, 0, 0);
        push_exp("x9_bypass_collide", K_DATA, 0, 32'hAA);
        push_exp("x9_busy_during_write", K_BUSY, 0, 32'h0);
        push_exp("count_x9", K_COUNT, 0, 32'd1);

        applyStimulus(0, 0, 0, 1, 9, 9, 0, 0);
        push_exp("x9_stored", K_DATA, 0, 32'hAA);
        push_exp("x9_still_busy", K_BUSY, 0, 32'h1);
        push_exp("count_collide", K_COUNT, 0, 32'd1);

        applyStimulus(1, 4, 32'h44, 1, 10, 9, 0, 0);
        push_exp("count_reclaim", K_COUNT, 0, 32'd1);
        push_exp("x9_reclaimed_busy", K_BUSY, 0, 32'h1);

        applyStimulus(1, 10, 32'h10, 1, 11, 4, 10, 9);
        push_exp("x4_written", K_DATA, 0, 32'h44);
        push_exp("x4_not_busy", K_BUSY, 0, 32'h0);
        push_exp("x10_writing_busy", K_BUSY, 1, 32'h0);
        push_exp("x9_busy_p2", K_BUSY, 2, 32'h1);
        push_exp("count_two", K_COUNT, 0, 32'd2);

        applyStimulus(1, 15, 32'hF0F0F0F0, 0, 0, 10, 11, 15);
        push_exp("x10_stored", K_DATA, 0, 32'h10);
        push_exp("x10_released", K_BUSY, 0, 32'h0);
        push_exp("x11_busy", K_BUSY, 1, 32'h1);
        push_exp("x15_bypass_p2", K_DATA, 2, 32'hF0F0F0F0);
        push_exp("count_swap", K_COUNT, 0, 32'd2);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 15);
        push_exp("x15_stored", K_DATA, 2, 32'hF0F0F0F0);
        push_exp("count_final", K_COUNT, 0, 32'd2);

        @(posedge clk);
        @(negedge clk);
        #1;
        total_checks++;
        if (exp_q.size() == 0) begin
            passed_checks++;
        end else begin
            $display("[TB] FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
